// File: rtl/tdp_ram_port_arbiter.sv
// Round-robin arbiter sharing one block-RAM port between NUM_REQ requesters.
// Optionally zero-fills the RAM after reset and tags each read response with its requester ID.
module tdp_ram_port_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned NUM_COL        = 4,
  parameter int unsigned COL_WIDTH      = 16,
  parameter int unsigned PIPELINE_DEPTH = 1,
  parameter bit          INIT_ON_RESET  = 1'b1,
  localparam int unsigned DW            = NUM_COL * COL_WIDTH,
  localparam int unsigned IDW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*NUM_COL-1:0]    req_wbe_i,
  input  logic [NUM_REQ*DW-1:0]         req_wdata_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic                          rvalid_o,
  output logic [IDW-1:0]                rid_o,
  output logic [DW-1:0]                 rdata_o,
  output logic                          init_done_o,
  output logic                          ram_en_o,
  output logic [NUM_COL-1:0]            ram_wbe_o,
  output logic [DW-1:0]                 ram_wdata_o,
  output logic [ADDR_WIDTH-1:0]         ram_addr_o,
  input  logic [DW-1:0]                 ram_rdata_i
);

  localparam int unsigned RL = PIPELINE_DEPTH + 1;

  typedef enum logic [0:0] {StInit, StArb} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [IDW-1:0]          ptr_q, ptr_d;
  logic                    init_done_q, init_done_d;
  logic [RL-1:0]           sr_valid_q, sr_valid_d;
  logic [RL-1:0][IDW-1:0]  sr_id_q, sr_id_d;

  logic                    found;
  logic                    granted;
  int unsigned             idx;
  int unsigned             win_idx;
  logic [NUM_COL-1:0]      win_wbe;
  logic                    push_valid;
  logic [IDW-1:0]          push_id;

  // Search starts at the pointer and wraps, so the first hit is the round-robin winner.
  always_comb begin
    found   = 1'b0;
    win_idx = 0;
    idx     = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!found && req_i[idx]) begin
        found   = 1'b1;
        win_idx = idx;
      end
    end
  end

  // Reset gating keeps gnt/ram_en low for the whole time rst_ni is held.
  assign granted = found && (state_q == StArb) && rst_ni;
  assign win_wbe = req_wbe_i[win_idx*NUM_COL +: NUM_COL];

  always_comb begin
    gnt_o = '0;
    if (granted) begin
      gnt_o[win_idx] = 1'b1;
    end
  end

  always_comb begin
    ram_en_o    = 1'b0;
    ram_wbe_o   = '0;
    ram_wdata_o = '0;
    ram_addr_o  = '0;
    if (state_q == StInit) begin
      ram_en_o    = rst_ni;
      ram_wbe_o   = '1;
      ram_addr_o  = cnt_q;
    end else if (granted) begin
      ram_en_o    = 1'b1;
      ram_wbe_o   = win_wbe;
      ram_wdata_o = req_wdata_i[win_idx*DW +: DW];
      ram_addr_o  = req_addr_i[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StInit: begin
        cnt_d = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == '1) begin
          state_d = StArb;
        end
      end
      StArb: begin
        if (granted) begin
          ptr_d = (win_idx == NUM_REQ - 1) ? '0 : IDW'(win_idx + 1);
        end
      end
      default: state_d = StArb;
    endcase
    init_done_d = (state_d == StArb);
  end

  // Only reads occupy a slot; writes and idle cycles shift in an empty entry.
  assign push_valid = granted && (win_wbe == '0);
  assign push_id    = push_valid ? IDW'(win_idx) : '0;

  always_comb begin
    sr_valid_d    = sr_valid_q;
    sr_id_d       = sr_id_q;
    sr_valid_d[0] = push_valid;
    sr_id_d[0]    = push_id;
    for (int unsigned i = 1; i < RL; i++) begin
      sr_valid_d[i] = sr_valid_q[i-1];
      sr_id_d[i]    = sr_id_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= INIT_ON_RESET ? StInit : StArb;
      cnt_q       <= '0;
      ptr_q       <= '0;
      init_done_q <= 1'b0;
      sr_valid_q  <= '0;
      sr_id_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      init_done_q <= init_done_d;
      sr_valid_q  <= sr_valid_d;
      sr_id_q     <= sr_id_d;
    end
  end

  assign rvalid_o    = sr_valid_q[RL-1];
  assign rid_o       = sr_id_q[RL-1];
  assign rdata_o     = ram_rdata_i;
  assign init_done_o = init_done_q;

  gnt_onehot_a: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_o));

endmodule

// File: tb/tb_tdp_ram_port_arbiter.sv
// Directed bench: main 4-requester instance with a RAM model, plus two small instances
// for read-latency timing at PIPELINE_DEPTH 0 and 3.
module tb_tdp_ram_port_arbiter;

  localparam logic [63:0] WD = 64'h1111_2222_3333_4444;
  localparam logic [63:0] RD = 64'h0000_2222_0000_4444;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Main DUT: NUM_REQ=4, ADDR_WIDTH=4, PIPELINE_DEPTH=1 (RL=2), INIT_ON_RESET=1
  logic [3:0]   req;
  logic [15:0]  req_wbe;
  logic [255:0] req_wdata;
  logic [15:0]  req_addr;
  logic [3:0]   gnt;
  logic         rvalid;
  logic [1:0]   rid;
  logic [63:0]  rdata;
  logic         init_done;
  logic         ram_en;
  logic [3:0]   ram_wbe;
  logic [63:0]  ram_wdata;
  logic [3:0]   ram_addr;
  logic [63:0]  ram_rdata;

  tdp_ram_port_arbiter #(
    .NUM_REQ(4), .ADDR_WIDTH(4), .NUM_COL(4), .COL_WIDTH(16),
    .PIPELINE_DEPTH(1), .INIT_ON_RESET(1'b1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .req_wbe_i(req_wbe),
    .req_wdata_i(req_wdata), .req_addr_i(req_addr), .gnt_o(gnt), .rvalid_o(rvalid),
    .rid_o(rid), .rdata_o(rdata), .init_done_o(init_done), .ram_en_o(ram_en),
    .ram_wbe_o(ram_wbe), .ram_wdata_o(ram_wdata), .ram_addr_o(ram_addr),
    .ram_rdata_i(ram_rdata)
  );

  // RAM model with latency 2: input register plus one output register.
  logic [63:0] mem [16];
  logic [63:0] rd0, rd1;
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wbe == 4'h0) begin
        rd0 <= mem[ram_addr];
      end
      for (int c = 0; c < 4; c++) begin
        if (ram_wbe[c]) mem[ram_addr][c*16 +: 16] <= ram_wdata[c*16 +: 16];
      end
    end
    rd1 <= rd0;
  end
  assign ram_rdata = rd1;

  // Small DUT A: NUM_REQ=1, PIPELINE_DEPTH=0
  logic        a_req, a_gnt, a_rvalid, a_rid, a_init_done, a_ram_en;
  logic [3:0]  a_wbe, a_addr, a_ram_wbe, a_ram_addr;
  logic [63:0] a_rdata, a_ram_wdata;

  tdp_ram_port_arbiter #(
    .NUM_REQ(1), .ADDR_WIDTH(4), .NUM_COL(4), .COL_WIDTH(16),
    .PIPELINE_DEPTH(0), .INIT_ON_RESET(1'b0)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(a_req), .req_wbe_i(a_wbe),
    .req_wdata_i(WD), .req_addr_i(a_addr), .gnt_o(a_gnt), .rvalid_o(a_rvalid),
    .rid_o(a_rid), .rdata_o(a_rdata), .init_done_o(a_init_done), .ram_en_o(a_ram_en),
    .ram_wbe_o(a_ram_wbe), .ram_wdata_o(a_ram_wdata), .ram_addr_o(a_ram_addr),
    .ram_rdata_i(64'h0)
  );

  // Small DUT B: NUM_REQ=2, PIPELINE_DEPTH=3
  logic [1:0]   b_req, b_gnt;
  logic         b_rvalid, b_rid, b_init_done, b_ram_en;
  logic [7:0]   b_wbe, b_addr;
  logic [3:0]   b_ram_wbe, b_ram_addr;
  logic [63:0]  b_rdata, b_ram_wdata;

  tdp_ram_port_arbiter #(
    .NUM_REQ(2), .ADDR_WIDTH(4), .NUM_COL(4), .COL_WIDTH(16),
    .PIPELINE_DEPTH(3), .INIT_ON_RESET(1'b0)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(b_req), .req_wbe_i(b_wbe),
    .req_wdata_i({2{WD}}), .req_addr_i(b_addr), .gnt_o(b_gnt), .rvalid_o(b_rvalid),
    .rid_o(b_rid), .rdata_o(b_rdata), .init_done_o(b_init_done), .ram_en_o(b_ram_en),
    .ram_wbe_o(b_ram_wbe), .ram_wdata_o(b_ram_wdata), .ram_addr_o(b_ram_addr),
    .ram_rdata_i(64'h0)
  );

  typedef struct {
    logic [3:0]  req;
    logic [15:0] wbe;
    logic [15:0] addr;
    logic [3:0]  gnt;
    logic        rvalid;
    logic [1:0]  rid;
    logic        chk_rd;
    logic [63:0] rdata;
  } vec_t;

  vec_t tbl [16];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] r, input logic [15:0] w, input logic [15:0] a,
                              input logic [3:0] g, input logic v, input logic [1:0] id,
                              input logic c, input logic [63:0] d);
    vec_t t;
    t.req = r; t.wbe = w; t.addr = a; t.gnt = g;
    t.rvalid = v; t.rid = id; t.chk_rd = c; t.rdata = d;
    return t;
  endfunction

  initial begin
    // Round-robin reads, then write/read-back of addr 5, then pointer wrap.
    tbl[0]  = mk(4'hF, 16'h0, 16'h0,    4'h1, 0, 0, 0, 64'h0);
    tbl[1]  = mk(4'hF, 16'h0, 16'h0,    4'h2, 0, 0, 0, 64'h0);
    tbl[2]  = mk(4'hF, 16'h0, 16'h0,    4'h4, 1, 0, 1, 64'h0);
    tbl[3]  = mk(4'hF, 16'h0, 16'h0,    4'h8, 1, 1, 1, 64'h0);
    tbl[4]  = mk(4'hF, 16'h0, 16'h0,    4'h1, 1, 2, 1, 64'h0);
    tbl[5]  = mk(4'hF, 16'h0, 16'h0,    4'h2, 1, 3, 1, 64'h0);
    tbl[6]  = mk(4'hF, 16'h0, 16'h0,    4'h4, 1, 0, 1, 64'h0);
    tbl[7]  = mk(4'hF, 16'h0, 16'h0,    4'h8, 1, 1, 1, 64'h0);
    tbl[8]  = mk(4'h4, 16'h0500, 16'h0500, 4'h4, 1, 2, 1, 64'h0);
    tbl[9]  = mk(4'h1, 16'h0, 16'h0005, 4'h1, 1, 3, 1, 64'h0);
    tbl[10] = mk(4'h2, 16'h0, 16'h0050, 4'h2, 0, 0, 0, 64'h0);
    tbl[11] = mk(4'h3, 16'h0, 16'h0055, 4'h1, 1, 0, 1, RD);
    tbl[12] = mk(4'h3, 16'h0, 16'h0055, 4'h2, 1, 1, 1, RD);
    tbl[13] = mk(4'h0, 16'h0, 16'h0,    4'h0, 1, 0, 1, RD);
    tbl[14] = mk(4'h0, 16'h0, 16'h0,    4'h0, 1, 1, 1, RD);
    tbl[15] = mk(4'h0, 16'h0, 16'h0,    4'h0, 0, 0, 0, 64'h0);

    rst_n = 1'b0;
    req = 4'hF; req_wbe = '0; req_wdata = {4{WD}}; req_addr = '0;
    a_req = 1'b0; a_wbe = '0; a_addr = '0;
    b_req = '0;   b_wbe = '0; b_addr = '0;

    // Reset values, with requests asserted
    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt", 64'(gnt), 64'h0);
    chk("rst_rvalid", 64'(rvalid), 64'h0);
    chk("rst_rid", 64'(rid), 64'h0);
    chk("rst_init_done", 64'(init_done), 64'h0);
    chk("rst_ram_en", 64'(ram_en), 64'h0);
    chk("rst_b_gnt", 64'(b_gnt), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero-fill sweep: requests ignored
    for (int i = 0; i < 16; i++) begin
      #1;
      chk($sformatf("init%0d_en", i), 64'(ram_en), 64'h1);
      chk($sformatf("init%0d_addr", i), 64'(ram_addr), 64'(i));
      chk($sformatf("init%0d_wbe", i), 64'(ram_wbe), 64'hF);
      chk($sformatf("init%0d_wdata", i), ram_wdata, 64'h0);
      chk($sformatf("init%0d_gnt", i), 64'(gnt), 64'h0);
      chk($sformatf("init%0d_done", i), 64'(init_done), 64'h0);
      @(negedge clk);
    end

    for (int v = 0; v < 16; v++) begin
      req = tbl[v].req; req_wbe = tbl[v].wbe; req_addr = tbl[v].addr;
      #1;
      chk($sformatf("v%0d_init_done", v), 64'(init_done), 64'h1);
      chk($sformatf("v%0d_gnt", v), 64'(gnt), 64'(tbl[v].gnt));
      chk($sformatf("v%0d_ram_en", v), 64'(ram_en), 64'(|tbl[v].gnt));
      chk($sformatf("v%0d_rvalid", v), 64'(rvalid), 64'(tbl[v].rvalid));
      chk($sformatf("v%0d_rid", v), 64'(rid), 64'(tbl[v].rid));
      if (tbl[v].chk_rd) chk($sformatf("v%0d_rdata", v), rdata, tbl[v].rdata);
      @(negedge clk);
    end

    // Reset with two reads in flight
    req = 4'h1; req_wbe = '0; req_addr = '0;
    #1 chk("t6_gnt_a", 64'(gnt), 64'h1);
    @(negedge clk);
    req = 4'h2;
    #1 chk("t6_gnt_b", 64'(gnt), 64'h2);
    #2 rst_n = 1'b0;
    req = 4'hF;
    #1;
    chk("t6_rst_gnt", 64'(gnt), 64'h0);
    chk("t6_rst_ram_en", 64'(ram_en), 64'h0);
    chk("t6_rst_rvalid", 64'(rvalid), 64'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk($sformatf("t6_rst%0d_rvalid", i), 64'(rvalid), 64'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t6_post%0d_rvalid", i), 64'(rvalid), 64'h0);
      chk($sformatf("t6_post%0d_addr", i), 64'(ram_addr), 64'(i));
      chk($sformatf("t6_post%0d_en", i), 64'(ram_en), 64'h1);
      chk($sformatf("t6_post%0d_gnt", i), 64'(gnt), 64'h0);
      @(negedge clk);
    end

    // Read latency at PIPELINE_DEPTH 0 (RL=1) and 3 (RL=4)
    a_req = 1'b1; a_wbe = 4'h0;
    b_req = 2'b10; b_wbe = 8'h00;
    #1;
    chk("t5_a_init_done", 64'(a_init_done), 64'h1);
    chk("t5_a_gnt", 64'(a_gnt), 64'h1);
    chk("t5_b_gnt", 64'(b_gnt), 64'h2);
    @(negedge clk);
    a_req = 1'b0; b_req = 2'b00;
    for (int k = 1; k <= 6; k++) begin
      #1;
      chk($sformatf("t5_rd_a_rvalid_k%0d", k), 64'(a_rvalid), 64'(k == 1));
      chk($sformatf("t5_rd_b_rvalid_k%0d", k), 64'(b_rvalid), 64'(k == 4));
      if (k == 4) chk("t5_rd_b_rid", 64'(b_rid), 64'h1);
      if (k == 1) chk("t5_rd_a_rid", 64'(a_rid), 64'h0);
      @(negedge clk);
    end
    a_req = 1'b1; a_wbe = 4'hF;
    b_req = 2'b01; b_wbe = 8'h0F;
    #1;
    chk("t5_wr_a_gnt", 64'(a_gnt), 64'h1);
    chk("t5_wr_b_gnt", 64'(b_gnt), 64'h1);
    @(negedge clk);
    a_req = 1'b0; b_req = 2'b00;
    for (int k = 1; k <= 6; k++) begin
      #1;
      chk($sformatf("t5_wr_a_rvalid_k%0d", k), 64'(a_rvalid), 64'h0);
      chk($sformatf("t5_wr_b_rvalid_k%0d", k), 64'(b_rvalid), 64'h0);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
